// File: rtl/fft_mag_streamer.sv
// Squares FFT bins into an N-entry frame buffer and streams each complete frame, followed by GAP idle cycles.
// Define MAG_SAT_EN to saturate scaled magnitudes at 2^W-1; the default build truncates to the low W bits.
module fft_mag_streamer #(
   parameter int W     = 16,
   parameter int N     = 8,
   parameter int IN_W  = 16,
   parameter int SHIFT = 8,
   parameter int GAP   = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic signed [IN_W-1:0] in_re,
   input  logic signed [IN_W-1:0] in_im,
   input  logic                   in_last,
   output logic                   mag_valid,
   output logic [W-1:0]           mag_sq,
   output logic                   frame_start,
   output logic                   frame_err
);

   localparam int CNT_W = $clog2(N);
   localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
   localparam int SQ_W  = 2 * IN_W + 1;

   typedef enum logic [1:0] {FILL, STREAM, DRAIN_GAP} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   bin_cnt_q, bin_cnt_d;
   logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
   logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
   logic               in_ready_q, in_ready_d;
   logic               mag_valid_q, mag_valid_d;
   logic [W-1:0]       mag_sq_q, mag_sq_d;
   logic               frame_start_q, frame_start_d;
   logic               frame_err_q, frame_err_d;
   logic               wr_en;
   logic [W-1:0]       mem_q [N];

   logic signed [2*IN_W-1:0] re_x, im_x, re_sq, im_sq;
   logic [SQ_W-1:0]          sq, sq_shift;
   logic [W-1:0]             mag;
   logic                     accept;

   assign accept = in_valid && in_ready_q;

   // Sign-extend first so the product is formed at full width with no wrap for the most negative input.
   assign re_x     = {{IN_W{in_re[IN_W-1]}}, in_re};
   assign im_x     = {{IN_W{in_im[IN_W-1]}}, in_im};
   assign re_sq    = re_x * re_x;
   assign im_sq    = im_x * im_x;
   assign sq       = SQ_W'($unsigned(re_sq)) + SQ_W'($unsigned(im_sq));
   assign sq_shift = sq >> SHIFT;

`ifdef MAG_SAT_EN
   assign mag = (sq_shift > SQ_W'({W{1'b1}})) ? {W{1'b1}} : sq_shift[W-1:0];
`else
   assign mag = W'(sq_shift);
`endif

   // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
   always_comb begin
      state_d       = state_q;
      bin_cnt_d     = bin_cnt_q;
      rd_cnt_d      = rd_cnt_q;
      gap_cnt_d     = gap_cnt_q;
      mag_valid_d   = 1'b0;
      mag_sq_d      = '0;
      frame_start_d = 1'b0;
      frame_err_d   = 1'b0;
      wr_en         = 1'b0;
      case (state_q)
         FILL: begin
            if (accept) begin
               wr_en = 1'b1;
               if (bin_cnt_q == CNT_W'(N - 1)) begin
                  // Bin 0 leaves on the same edge that captures bin N-1.
                  state_d       = STREAM;
                  bin_cnt_d     = '0;
                  rd_cnt_d      = CNT_W'(1);
                  mag_valid_d   = 1'b1;
                  mag_sq_d      = mem_q[0];
                  frame_start_d = 1'b1;
                  frame_err_d   = !in_last;
               end else if (in_last) begin
                  bin_cnt_d   = '0;
                  frame_err_d = 1'b1;
               end else begin
                  bin_cnt_d = bin_cnt_q + CNT_W'(1);
               end
            end
         end
         STREAM: begin
            if (rd_cnt_q == '0) begin
               state_d   = DRAIN_GAP;
               gap_cnt_d = '0;
            end else begin
               mag_valid_d = 1'b1;
               mag_sq_d    = mem_q[rd_cnt_q];
               rd_cnt_d    = rd_cnt_q + CNT_W'(1);
            end
         end
         DRAIN_GAP: begin
            if (gap_cnt_q == GAP_W'(GAP - 1)) begin
               state_d   = FILL;
               gap_cnt_d = '0;
            end else begin
               gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
         end
         default: state_d = FILL;
      endcase
      in_ready_d = (state_d == FILL);
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= FILL;
         bin_cnt_q     <= '0;
         rd_cnt_q      <= '0;
         gap_cnt_q     <= '0;
         in_ready_q    <= 1'b1;
         mag_valid_q   <= 1'b0;
         mag_sq_q      <= '0;
         frame_start_q <= 1'b0;
         frame_err_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         bin_cnt_q     <= bin_cnt_d;
         rd_cnt_q      <= rd_cnt_d;
         gap_cnt_q     <= gap_cnt_d;
         in_ready_q    <= in_ready_d;
         mag_valid_q   <= mag_valid_d;
         mag_sq_q      <= mag_sq_d;
         frame_start_q <= frame_start_d;
         frame_err_q   <= frame_err_d;
      end
   end

   // NOTE: the frame buffer is not reset; an entry is only read after this frame has written it.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[bin_cnt_q] <= mag;
   end

   assign in_ready    = in_ready_q;
   assign mag_valid   = mag_valid_q;
   assign mag_sq      = mag_sq_q;
   assign frame_start = frame_start_q;
   assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_fft_mag_streamer.sv
// Scoreboard bench for fft_mag_streamer: each completed input frame queues its expected bins, and a
// monitor on the falling edge pops and compares them. Honours MAG_SAT_EN in its reference model.
module tb_fft_mag_streamer;

   localparam int W     = 16;
   localparam int N     = 8;
   localparam int IN_W  = 16;
   localparam int SHIFT = 8;
   localparam int GAP   = 2;

   logic                   clk = 1'b0;
   logic                   reset;
   logic                   in_valid;
   logic                   in_ready;
   logic signed [IN_W-1:0] in_re;
   logic signed [IN_W-1:0] in_im;
   logic                   in_last;
   logic                   mag_valid;
   logic [W-1:0]           mag_sq;
   logic                   frame_start;
   logic                   frame_err;

   typedef struct {
      logic [W-1:0] mag;
      logic         first;
   } exp_t;

   exp_t         sb_q[$];
   logic [W-1:0] frame_buf [N];
   int           tb_cnt    = 0;
   int           last_wait = 0;
   int           n_vec     = 0;
   int           n_err     = 0;

   fft_mag_streamer #(.W(W), .N(N), .IN_W(IN_W), .SHIFT(SHIFT), .GAP(GAP)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_re       (in_re),
      .in_im       (in_im),
      .in_last     (in_last),
      .mag_valid   (mag_valid),
      .mag_sq      (mag_sq),
      .frame_start (frame_start),
      .frame_err   (frame_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] model(input int re, input int im);
      longint sq, sh, maxv;
      sq   = longint'(re) * longint'(re) + longint'(im) * longint'(im);
      sh   = sq >> SHIFT;
      maxv = (longint'(1) << W) - 1;
`ifdef MAG_SAT_EN
      return (sh > maxv) ? W'(maxv) : W'(sh);
`else
      return W'(sh & maxv);
`endif
   endfunction

   // Presents one bin, waits (bounded) for in_ready, then updates the reference frame model.
   task automatic send_bin(input int re, input int im, input bit last);
      bit complete;
      bit exp_err;
      in_valid  = 1'b1;
      in_re     = IN_W'(re);
      in_im     = IN_W'(im);
      in_last   = last;
      last_wait = 0;
      @(negedge clk);
      while (!in_ready && last_wait < 64) begin
         @(negedge clk);
         last_wait++;
      end
      if (!in_ready) begin
         check("ready_timeout", {63'd0, in_ready}, 64'd1);
         return;
      end
      @(posedge clk);
      #1;
      frame_buf[tb_cnt] = model(re, im);
      complete = (tb_cnt == N - 1);
      exp_err  = complete ? !last : last;
      if (complete) begin
         for (int i = 0; i < N; i++) sb_q.push_back('{mag: frame_buf[i], first: (i == 0)});
         tb_cnt = 0;
      end else if (last) begin
         tb_cnt = 0;
      end else begin
         tb_cnt++;
      end
      check("frame_err", {63'd0, frame_err}, {63'd0, exp_err});
      check("bin0_latency", {63'd0, mag_valid}, {63'd0, complete});
      check("in_ready_after", {63'd0, in_ready}, {63'd0, !complete});
   endtask

   task automatic idle(input int cycles);
      in_valid = 1'b0;
      in_last  = 1'b0;
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int t = 0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      while (sb_q.size() != 0 && t < 200) begin
         @(posedge clk);
         t++;
      end
      repeat (GAP + 2) @(posedge clk);
      #1;
      check("drain_empty", 64'(sb_q.size()), 64'd0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         if (mag_valid) begin
            if (sb_q.size() == 0) begin
               check("unexpected_valid", {63'd0, mag_valid}, 64'd0);
            end else begin
               e = sb_q.pop_front();
               check("mag_sq", 64'(mag_sq), 64'(e.mag));
               check("frame_start", {63'd0, frame_start}, {63'd0, e.first});
            end
         end else begin
            check("idle_outputs", {47'd0, frame_start, mag_sq}, 64'd0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      int v;
      reset    = 1'b1;
      in_valid = 1'b0;
      in_re    = '0;
      in_im    = '0;
      in_last  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", {63'd0, in_ready}, 64'd1);
      check("rst_mag_valid", {63'd0, mag_valid}, 64'd0);
      check("rst_mag_sq", 64'(mag_sq), 64'd0);
      check("rst_frame_start", {63'd0, frame_start}, 64'd0);
      check("rst_frame_err", {63'd0, frame_err}, 64'd0);
      @(negedge clk) reset = 1'b0;
      @(posedge clk);
      #1;

      // Constant bins 300 + j400.
      for (int k = 0; k < N; k++) send_bin(300, 400, k == N - 1);
      drain();

      // Ramp on the real axis.
      for (int k = 0; k < N; k++) send_bin(k * 16, 0, k == N - 1);
      drain();

      // Most negative inputs: saturation vs truncation.
      for (int k = 0; k < N; k++) send_bin(-32768, -32768, k == N - 1);
      drain();

      // Early in_last drops the partial frame; the next frame is clean.
      for (int k = 0; k < 4; k++) send_bin(1000 + k, -77, k == 3);
      idle(3);
      check("short_frame_no_output", 64'(sb_q.size()), 64'd0);
      for (int k = 0; k < N; k++) send_bin(k * 100 - 350, 50 * k, k == N - 1);
      drain();

      // Missing in_last on bin N-1 still streams.
      for (int k = 0; k < N; k++) send_bin(-200 * k, 123, 1'b0);
      drain();

      // Back-to-back frames with in_valid never dropping.
      for (int k = 0; k < N; k++) send_bin(k * 37, -k * 41, k == N - 1);
      send_bin(5000, 6000, 1'b0);
      check("stall_cycles", 64'(last_wait), 64'(N + GAP));
      for (int k = 1; k < N; k++) send_bin(5000 - k * 600, 6000 - k * 900, k == N - 1);
      drain();

      // Random bins with sporadic in_valid gaps.
      for (int f = 0; f < 2; f++) begin
         for (int k = 0; k < N; k++) begin
            send_bin(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
                     k == N - 1);
            idle(int'($urandom_range(0, 2)));
         end
      end
      drain();

      // Reset while bin 4 is on the output.
      for (int k = 0; k < N; k++) send_bin(64 * k + 10, 20, k == N - 1);
      repeat (4) @(posedge clk);
      #1;
      check("pre_rst_valid", {63'd0, mag_valid}, 64'd1);
      in_valid = 1'b0;
      in_last  = 1'b0;
      reset    = 1'b1;
      #1;
      check("async_rst_valid", {63'd0, mag_valid}, 64'd0);
      check("async_rst_mag", 64'(mag_sq), 64'd0);
      check("async_rst_ready", {63'd0, in_ready}, 64'd1);
      sb_q.delete();
      tb_cnt = 0;
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b0;
      v = 0;
      repeat (20) begin
         @(negedge clk);
         if (mag_valid) v++;
      end
      check("no_residual_bins", 64'(v), 64'd0);
      check("post_rst_ready", {63'd0, in_ready}, 64'd1);
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) send_bin(-k * 300, k * 250, k == N - 1);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
